// File: rtl/vga_bounce_engine.sv
// vga_bounce_engine: parametrised VGA timing generator with a frame-synchronous bouncing sprite.
// Optional macro VGA_BOUNCE_BORDER_EN draws a one-pixel ~bg_color border around the active area.
`default_nettype none

module vga_bounce_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int RECT_W   = 32,
  parameter int RECT_H   = 24,
  parameter int CW       = 11,
  parameter int COLOR_W  = 8,
  parameter int SPD_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] rect_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic [SPD_W-1:0]   speed,
  input  logic               pause,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] color,
  output logic               frame_tick,
  output logic               corner_hit,
  output logic [15:0]        bounce_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EDGE   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_EDGE   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] X_MAX    = CW'(H_ACTIVE - RECT_W);
  localparam logic [CW-1:0] Y_MAX    = CW'(V_ACTIVE - RECT_H);
  localparam logic [CW:0]   RW       = (CW+1)'(RECT_W);
  localparam logic [CW:0]   RH       = (CW+1)'(RECT_H);

  logic [DW-1:0]      div;
  logic               pix_ce;
  logic [CW-1:0]      hcnt, vcnt;
  logic [CW-1:0]      pos_x, pos_y;
  logic               dir_x, dir_y;   // 0 = increasing, 1 = decreasing
  logic [CW-1:0]      nx_x, nx_y;
  logic               flip_x, flip_y, move;
  logic               in_rect, border, act;
  logic [COLOR_W-1:0] pix_color;

  // Returns {flip, new_pos}; CW+1 bit arithmetic so pos+speed cannot overflow.
  function automatic logic [CW:0] axis_step(input logic [CW-1:0] pos, input logic dir,
                                            input logic [SPD_W-1:0] spd, input logic [CW-1:0] lim);
    logic [CW:0] s;
    logic [CW:0] sum;
    s   = (CW+1)'(spd);
    sum = {1'b0, pos} + s;
    if (!dir) begin
      if (sum >= {1'b0, lim}) axis_step = {1'b1, lim};
      else                    axis_step = {1'b0, sum[CW-1:0]};
    end else begin
      if ({1'b0, pos} <= s)   axis_step = {1'b1, {CW{1'b0}}};
      else                    axis_step = {1'b0, pos - s[CW-1:0]};
    end
  endfunction

  assign pix_ce     = (div == DIV_LAST);
  assign frame_tick = pix_ce && (hcnt == H_LAST) && (vcnt == V_EDGE);
  assign move       = frame_tick && !pause && (speed != '0);
  assign act        = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign in_rect    = ({1'b0, hcnt} >= {1'b0, pos_x}) && ({1'b0, hcnt} < {1'b0, pos_x} + RW) &&
                      ({1'b0, vcnt} >= {1'b0, pos_y}) && ({1'b0, vcnt} < {1'b0, pos_y} + RH);

`ifdef VGA_BOUNCE_BORDER_EN
  assign border = (hcnt == '0) || (hcnt == H_EDGE) || (vcnt == '0) || (vcnt == V_EDGE);
`else
  assign border = 1'b0;
`endif

  always_comb begin
    {flip_x, nx_x} = axis_step(pos_x, dir_x, speed, X_MAX);
    {flip_y, nx_y} = axis_step(pos_y, dir_y, speed, Y_MAX);
    pix_color = '0;
    if (act) begin
      if (in_rect)     pix_color = rect_color;
      else if (border) pix_color = ~bg_color;
      else             pix_color = bg_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      de         <= 1'b0;
      color      <= '0;
      corner_hit <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      corner_hit <= 1'b0;
      div        <= pix_ce ? '0 : div + 1'b1;
      if (pix_ce) begin
        // Outputs use the pre-increment counters: one pixel of latency, all aligned.
        hsync <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
        vsync <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
        de    <= act;
        color <= pix_color;
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
      if (move) begin
        pos_x <= nx_x;
        pos_y <= nx_y;
        if (flip_x) dir_x <= ~dir_x;
        if (flip_y) dir_y <= ~dir_y;
        if (flip_x || flip_y) bounce_cnt <= bounce_cnt + 16'd1;
        corner_hit <= flip_x && flip_y;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_bounce_engine.sv
// Randomised bench for vga_bounce_engine on a reduced timing, checked cycle by cycle
// against a pixel-index reference model (raster position derived from elapsed clocks).
`default_nettype none

module tb_vga_bounce_engine;

  localparam int HA = 24, HF = 2, HS = 3, HB = 3;
  localparam int VA = 16, VF = 1, VS = 2, VB = 2;
  localparam int D  = 2;
  localparam int RW = 6, RH = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XM = HA - RW;
  localparam int YM = VA - RH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rect_color = 8'hE0;
  logic [7:0] bg_color = 8'h03;
  logic [3:0] speed = 4'd1;
  logic       pause = 1'b0;
  logic       hsync, vsync, de, frame_tick, corner_hit;
  logic [7:0] color;
  logic [15:0] bounce_cnt;

  vga_bounce_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(D), .RECT_W(RW), .RECT_H(RH), .CW(8), .COLOR_W(8), .SPD_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rect_color(rect_color), .bg_color(bg_color),
    .speed(speed), .pause(pause), .hsync(hsync), .vsync(vsync), .de(de),
    .color(color), .frame_tick(frame_tick), .corner_hit(corner_hit), .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: clocks since release, sprite position/direction, expected outputs.
  int  n, mx, my, mcnt, frames, corners;
  bit  mdx, mdy;               // 1 = moving toward 0
  bit  e_hs, e_vs, e_de, e_corner, e_tick;
  int  e_col;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
    e_hs = 1; e_vs = 1; e_de = 0; e_col = 0; e_corner = 0; e_tick = 0;
  endtask

  task automatic axis(inout int p, inout bit d, input int s, input int lim, output bit fl);
    fl = 0;
    if (!d) begin
      if (p + s >= lim) begin p = lim; fl = 1; end else p = p + s;
    end else begin
      if (p <= s) begin p = 0; fl = 1; end else p = p - s;
    end
    if (fl) d = ~d;
  endtask

  // Advance the model over one clock edge (edge index n), using inputs as seen at that edge.
  task automatic model_step();
    int q, h, v;
    bit fx, fy;
    e_corner = 0;
    if (n % D == D - 1) begin
      q = n / D; h = q % HT; v = (q / HT) % VT;
      e_hs = !(h >= HA + HF && h < HA + HF + HS);
      e_vs = !(v >= VA + VF && v < VA + VF + VS);
      e_de = (h < HA) && (v < VA);
      if (!e_de) e_col = 0;
      else if (h >= mx && h < mx + RW && v >= my && v < my + RH) e_col = rect_color;
`ifdef VGA_BOUNCE_BORDER_EN
      else if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) e_col = 8'(~bg_color);
`endif
      else e_col = bg_color;
      if (h == HT - 1 && v == VA - 1) begin
        frames++;
        if (!pause && speed != 0) begin
          axis(mx, mdx, int'(speed), XM, fx);
          axis(my, mdy, int'(speed), YM, fy);
          if (fx || fy) mcnt = (mcnt + 1) & 16'hFFFF;
          e_corner = fx && fy;
          if (e_corner) corners++;
        end
      end
    end
    n++;
    q = n / D;
    e_tick = (n % D == D - 1) && (q % HT == HT - 1) && ((q / HT) % VT == VA - 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_de"}, int'(de), 0);
    check({tag, "_color"}, int'(color), 0);
    check({tag, "_tick"}, int'(frame_tick), 0);
    check({tag, "_corner"}, int'(corner_hit), 0);
    check({tag, "_bcnt"}, int'(bounce_cnt), 0);
  endtask

  initial begin
    frames = 0; corners = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 60000 && fails <= 50; cyc++) begin
      @(negedge clk);
      model_step();
      check("hsync", int'(hsync), int'(e_hs));
      check("vsync", int'(vsync), int'(e_vs));
      check("de", int'(de), int'(e_de));
      check("color", int'(color), e_col);
      check("frame_tick", int'(frame_tick), int'(e_tick));
      check("corner_hit", int'(corner_hit), int'(e_corner));
      check("bounce_cnt", int'(bounce_cnt), mcnt);

      if ($urandom_range(0, 499) == 0) begin
        speed = 4'($urandom_range(0, 9));
        pause = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        rect_color = 8'($urandom);
        bg_color   = 8'($urandom);
      end

      // Mid-frame asynchronous reset: outputs must clear without waiting for a clock.
      if (cyc == 31337) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst_hold");
        model_reset();
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
